// File: rtl/rep_mon_pkg.sv
// rep_window_monitor shared types.
// FSM states and fail code encodings.
package rep_mon_pkg;

  localparam int FC_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    QUAL  = 2'd2
  } state_t;

  typedef enum logic [FC_W-1:0] {
    FC_NONE     = 2'd0,
    FC_WIN_DROP = 2'd1,
    FC_OVER     = 2'd2,
    FC_TMO      = 2'd3
  } fail_code_t;

endpackage

// File: rtl/rep_mon_timer.sv
// rep_window_monitor check timer.
// Counts busy edges after the start edge.
module rep_mon_timer #(
  parameter int TIMEOUT = 32,
  parameter int TMO_W   = $clog2(TIMEOUT+1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam logic [TMO_W-1:0] MAX  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT-1);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run && cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt lags the edge ordinal by one: this edge is the TIMEOUT-th
  assign expired = run & (cnt == LAST);

endmodule

// File: rtl/rep_window_monitor.sv
// Windowed evt[=N_REP] ##1 qual run-time monitor.
// Reports pass/fail pulses and a held fail code.
module rep_window_monitor
  import rep_mon_pkg::*;
#(
  parameter int N_REP   = 5,
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = $clog2(N_REP+1),
  parameter int TMO_W   = $clog2(TIMEOUT+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             win,
  input  logic             evt,
  input  logic             qual,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [FC_W-1:0]  fail_code,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam logic [CNT_W-1:0] NMAX = CNT_W'(N_REP);

  state_t           state, state_n;
  fail_code_t       code, code_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             win_q;
  logic             pass_n, fail_n;
  logic             start, expired;

  assign start   = (state == IDLE) & en & win & ~win_q;
  assign cnt_inc = cnt + CNT_W'(evt);

  rep_mon_timer #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start),
    .run     (busy),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      code  <= FC_NONE;
      cnt   <= '0;
      win_q <= 1'b0;
      pass  <= 1'b0;
      fail  <= 1'b0;
    end else begin
      state <= state_n;
      code  <= code_n;
      cnt   <= cnt_n;
      win_q <= win;
      pass  <= pass_n;
      fail  <= fail_n;
    end
  end

  always_comb begin
    state_n = state;
    code_n  = code;
    cnt_n   = cnt;
    pass_n  = 1'b0;
    fail_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          cnt_n   = CNT_W'(evt);
          code_n  = FC_NONE;
          state_n = (evt && N_REP == 1) ? QUAL : COUNT;
        end
      end
      COUNT: begin
        if (!en) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc;
          // reaching N_REP outranks a window drop on the same edge
          if (cnt_inc == NMAX) begin
            state_n = QUAL;
          end else if (!win) begin
            state_n = IDLE;
            fail_n  = 1'b1;
            code_n  = FC_WIN_DROP;
          end else if (expired) begin
            state_n = IDLE;
            fail_n  = 1'b1;
            code_n  = FC_TMO;
          end
        end
      end
      QUAL: begin
        if (!en) begin
          state_n = IDLE;
        end else if (qual) begin
          state_n = IDLE;
          pass_n  = 1'b1;
        end else if (evt) begin
          state_n = IDLE;
          fail_n  = 1'b1;
          code_n  = FC_OVER;
        end else if (expired) begin
          state_n = IDLE;
          fail_n  = 1'b1;
          code_n  = FC_TMO;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign fail_code = code;
  assign evt_cnt   = cnt;

endmodule

// File: doc/rep_window_monitor.md
# rep_window_monitor

Synthesizable run-time monitor for windowed non-consecutive repetition with a late qualifying event. A rising edge on `win` opens a check window. The block then counts exactly `N_REP` cycles of `evt`, which need not be consecutive, while `win` is held. It then waits for `qual` in a later cycle, bounded by a timeout. It sits beside the datapath under observation and reports pass/fail pulses plus a fail code to the status/interrupt logic, giving silicon the same checking that the formal `evt[=N] ##1 qual` properties give in simulation.

## Interface
- `N_REP`, 5, required number of `evt`-high cycles per window (≥1).
- `TIMEOUT`, 32, max edges from start to the pass decision (> `N_REP`).
- `CNT_W`, `$clog2(N_REP+1)`, derived; do not override.
- `TMO_W`, `$clog2(TIMEOUT+1)`, derived; do not override.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: monitor enable.
- `win` in 1: window signal; its rising edge starts a check.
- `evt` in 1: counted event, one count per high cycle.
- `qual` in 1: qualifying event.
- `busy` out 1: a check is in progress (state ≠ IDLE).
- `pass` out 1: one-cycle pulse on success.
- `fail` out 1: one-cycle pulse on failure.
- `fail_code` out 2: 0 NONE, 1 WIN_DROP, 2 OVER, 3 TMO; valid with `fail`, held until next start.
- `evt_cnt` out CNT_W: current count, saturates at `N_REP`, held after the report.

## Operation
- All inputs are sampled on `posedge clk`. `win_q` is a registered copy of `win`.
- Start = `en & win & !win_q` while in IDLE. On start: clear `evt_cnt`, timer and `fail_code`; enter COUNT.
- A `win` rise while busy is ignored; it is not queued.
- The start edge itself counts: if `evt`=1 at the start edge, `evt_cnt` becomes 1.
- **IDLE**: outputs quiescent; wait for start.
- **COUNT**: each edge with `evt`=1 increments `evt_cnt`.
  - When the count reaches `N_REP`, go to QUAL. This takes priority over `win` being low on the same edge.
  - Otherwise, if `win`=0: fail WIN_DROP, go to IDLE.
- **QUAL** (first evaluated at the edge after the Nth `evt`), checked in this priority order:
  - `qual`=1 → pass, go to IDLE. `evt` on the same edge is don't-care.
  - `evt`=1 → fail OVER, go to IDLE.
  - Timeout → fail TMO, go to IDLE.
  - `win` is don't-care in QUAL.
- **Timer**: 0 at the start edge, +1 on each busy edge.
  - Timeout fires at edge start+`TIMEOUT` in COUNT or QUAL, with lowest priority.
  - In COUNT, WIN_DROP beats TMO.
- `qual` during COUNT, including at the Nth `evt` edge, is ignored.
- `en`=0 while busy: abort to IDLE with no pass/fail pulse; `evt_cnt` holds.
- `rst_n`=0 asynchronously clears state to IDLE and `win_q`, `busy`, `pass`, `fail`, `fail_code`, `evt_cnt` and the timer to 0.

## Timing
- The decision is made at edge d; `pass`/`fail`/`fail_code` are registered and visible from edge d until edge d+1 (one cycle). `busy` drops at the same edge.
- Minimum start-to-pass latency is `N_REP` edges: `evt` high at every edge from start, then `qual` at start+`N_REP`.
- A new start is accepted at the edge after the report, if `win` shows a fresh rise.
- `pass` and `fail` are never high together.

## Structure
- Package `rep_mon_pkg`:
  - `state_t` enum {IDLE, COUNT, QUAL};
  - `fail_code_t` enum {FC_NONE, FC_WIN_DROP, FC_OVER, FC_TMO};
  - encoding constants.
- Sub-module `rep_mon_timer` (params `TIMEOUT`, `TMO_W`): inputs `clk`, `rst_n`, `clr`, `run`; output `expired`, high when the count equals `TIMEOUT`.
- The top holds the FSM, the edge detector and the `evt` counter.

## Test plan
- `win` rises at edge 1; `evt` pulses at edges 2, 4, 6, 8, 10; `qual` at edge 12 → `pass` at edge 12–13, `evt_cnt`=5, `fail`=0.
- Same stimulus plus an extra `evt` at edge 11 → `fail` with `fail_code`=2 (OVER) at edge 11.
- `evt` pulses at edges 2, 4, 6; `win` falls at edge 7 → `fail` with `fail_code`=1 (WIN_DROP) at edge 7, `evt_cnt`=3.
- Five `evt` pulses and no `qual`, start at edge 1 → `fail` with `fail_code`=3 (TMO) at edge 33.
- `evt` high at edges 1–5 (start at 1) with `qual` also at edge 5 → no pass at edge 5; `qual` at edge 6 → `pass`.
- Abort and reset:
  - `en` drops mid-COUNT → `busy`=0 next edge, no pulse.
  - `rst_n` low mid-QUAL → all outputs 0 immediately, without waiting for an edge.
  - A `win` rise while busy → ignored.
